instruction_queue: RTL and testbench

- Circular FIFO between the decoder and the bus arbiter.
- Buffers decoded instructions and their target reservation station.
- Presents the oldest entry as fetch_valid / fetch_target_rs / fetch_op_spec.
- Pops the head when the arbiter asserts QueuePolled; supports a single-cycle flush for branch redirect.

---
 rtl/instruction_queue.sv | 144 ++++++++++++++
 tb/tb_instruction_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// Circular instruction FIFO between the decoder and the bus arbiter, tagging each entry with its target RS.
// Optional same-cycle empty-queue bypass is enabled by defining INSTRUCTION_QUEUE_BYPASS_EN.

package types;
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [7:0] imm;
    } operation_specification;
endpackage

module instruction_queue #(
    parameter int DEPTH    = 8,
    parameter int RS_COUNT = 3
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          flush,
    input  logic                                          enq_valid,
    output logic                                          enq_ready,
    input  logic [2:0]                                    enq_target_rs,
    input  logic [$bits(types::operation_specification)-1:0] enq_op_spec,
    output logic                                          fetch_valid,
    output logic [2:0]                                    fetch_target_rs,
    output logic [$bits(types::operation_specification)-1:0] fetch_op_spec,
    input  logic                                          QueuePolled,
    output logic [$clog2(DEPTH+1)-1:0]                    count,
    output logic                                          full,
    output logic                                          empty,
    output logic                                          bad_target
);

    localparam int OP_W  = $bits(types::operation_specification);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [2:0]      r_target [DEPTH];
    logic [OP_W-1:0] r_op     [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_bad_target;

    logic            w_full;
    logic            w_empty;
    logic            w_legal;
    logic            w_offer;
    logic            w_enq;
    logic            w_drop;
    logic            w_bypass;
    logic            w_fetch_valid;
    logic [2:0]      w_fetch_target;
    logic [OP_W-1:0] w_fetch_op;
    logic            w_deq;
    logic            w_push;
    logic            w_pop;
    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] w_tail_next;

    always_comb begin
        w_full  = (r_count == DEPTH_CNT);
        w_empty = (r_count == '0);
        w_legal = (int'(enq_target_rs) < RS_COUNT);
        w_offer = enq_valid && !w_full && !flush;
        w_enq   = w_offer && w_legal;
        w_drop  = w_offer && !w_legal;

        w_head_next = (r_head == LAST_IDX) ? '0 : r_head + PTR_W'(1);
        w_tail_next = (r_tail == LAST_IDX) ? '0 : r_tail + PTR_W'(1);

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
        w_bypass = w_empty && w_enq;
`else
        w_bypass = 1'b0;
`endif

        // Empty queue presents zeros unless a bypassed instruction is on the input.
        w_fetch_valid  = !w_empty || w_bypass;
        w_fetch_target = '0;
        w_fetch_op     = '0;
        if (!w_empty) begin
            w_fetch_target = r_target[r_head];
            w_fetch_op     = r_op[r_head];
        end else if (w_bypass) begin
            w_fetch_target = enq_target_rs;
            w_fetch_op     = enq_op_spec;
        end

        w_deq  = QueuePolled && w_fetch_valid && !flush;
        w_pop  = w_deq && !w_empty;
        w_push = w_enq && !(w_bypass && w_deq);
    end

    // Flush wins over any enqueue/dequeue; bad_target is sticky until reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_target[i] <= '0;
                r_op[i]     <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_bad_target <= 1'b0;
        end else begin
            if (w_drop) begin
                r_bad_target <= 1'b1;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_target[r_tail] <= enq_target_rs;
                    r_op[r_tail]     <= enq_op_spec;
                    r_tail           <= w_tail_next;
                end
                if (w_pop) begin
                    r_head <= w_head_next;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign enq_ready       = !w_full;
    assign full            = w_full;
    assign empty           = w_empty;
    assign count           = r_count;
    assign bad_target      = r_bad_target;
    assign fetch_valid     = w_fetch_valid;
    assign fetch_target_rs = w_fetch_target;
    assign fetch_op_spec   = w_fetch_op;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus randomized traffic against a queue model.
// Honours INSTRUCTION_QUEUE_BYPASS_EN in the reference model when it is defined.

module tb_instruction_queue;

    localparam int DEPTH    = 4;
    localparam int RS_COUNT = 3;
    localparam int OPW      = $bits(types::operation_specification);
    localparam int CNTW     = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [2:0]      enq_target_rs = '0;
    logic [OPW-1:0]  enq_op_spec = '0;
    logic            fetch_valid;
    logic [2:0]      fetch_target_rs;
    logic [OPW-1:0]  fetch_op_spec;
    logic            QueuePolled = 1'b0;
    logic [CNTW-1:0] count;
    logic            full;
    logic            empty;
    logic            bad_target;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [2:0]     t;
        logic [OPW-1:0] op;
    } entry_t;

    entry_t modelQ[$];
    bit     modelBad = 1'b0;

    instruction_queue #(.DEPTH(DEPTH), .RS_COUNT(RS_COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_target_rs(enq_target_rs), .enq_op_spec(enq_op_spec),
        .fetch_valid(fetch_valid), .fetch_target_rs(fetch_target_rs),
        .fetch_op_spec(fetch_op_spec), .QueuePolled(QueuePolled),
        .count(count), .full(full), .empty(empty), .bad_target(bad_target)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit bypassActive();
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
        return (modelQ.size() == 0) && enq_valid && !flush && (enq_target_rs < RS_COUNT);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: plain queue semantics evaluated at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            modelBad = 1'b0;
        end else if (flush) begin
            modelQ.delete();
        end else begin
            bit hasRoom, legal, fv, deq, enq, byp;
            hasRoom = modelQ.size() < DEPTH;
            legal   = enq_target_rs < RS_COUNT;
            byp     = bypassActive();
            fv      = (modelQ.size() > 0) || byp;
            deq     = QueuePolled && fv;
            enq     = enq_valid && hasRoom && legal;
            if (enq_valid && hasRoom && !legal) modelBad = 1'b1;
            if (!(byp && deq)) begin
                if (deq) void'(modelQ.pop_front());
                if (enq) modelQ.push_back('{enq_target_rs, enq_op_spec});
            end
        end
    end

    // Compare all outputs against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        logic            expValid;
        logic [2:0]      expT;
        logic [OPW-1:0]  expOp;
        expValid = 1'b0;
        expT     = '0;
        expOp    = '0;
        if (modelQ.size() > 0) begin
            expValid = 1'b1;
            expT     = modelQ[0].t;
            expOp    = modelQ[0].op;
        end else if (bypassActive()) begin
            expValid = 1'b1;
            expT     = enq_target_rs;
            expOp    = enq_op_spec;
        end
        checkOutput("count", 64'(count), 64'(modelQ.size()));
        checkOutput("full", 64'(full), 64'(modelQ.size() == DEPTH));
        checkOutput("empty", 64'(empty), 64'(modelQ.size() == 0));
        checkOutput("enq_ready", 64'(enq_ready), 64'(modelQ.size() < DEPTH));
        checkOutput("fetch_valid", 64'(fetch_valid), 64'(expValid));
        checkOutput("fetch_target_rs", 64'(fetch_target_rs), 64'(expT));
        checkOutput("fetch_op_spec", 64'(fetch_op_spec), 64'(expOp));
        checkOutput("bad_target", 64'(bad_target), 64'(modelBad));
    end

    // Drive one cycle of inputs, then return the bus to idle just after the edge.
    task automatic applyStimulus(input bit ev, input logic [2:0] tgt, input bit poll, input bit fl);
        enq_valid     = ev;
        enq_target_rs = tgt;
        enq_op_spec   = OPW'($urandom);
        QueuePolled   = poll;
        flush         = fl;
        @(posedge clk);
        #1;
        enq_valid     = 1'b0;
        enq_target_rs = '0;
        enq_op_spec   = '0;
        QueuePolled   = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        logic [2:0] seq [4];
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("lit_reset_count", 64'(count), 64'd0);
        checkOutput("lit_reset_empty", 64'(empty), 64'd1);
        checkOutput("lit_reset_op", 64'(fetch_op_spec), 64'd0);
        checkOutput("lit_reset_valid", 64'(fetch_valid), 64'd0);
        applyStimulus(0, 0, 0, 0);

        // Fill to capacity, then offer one more.
        for (int i = 0; i < 4; i++) applyStimulus(1, seq[i], 0, 0);
        checkOutput("lit_full_count", 64'(count), 64'd4);
        checkOutput("lit_full_flag", 64'(full), 64'd1);
        checkOutput("lit_full_ready", 64'(enq_ready), 64'd0);
        applyStimulus(1, 3'd1, 0, 0);
        checkOutput("lit_fifth_rejected", 64'(count), 64'd4);

        for (int i = 0; i < 4; i++) begin
            checkOutput("lit_drain_target", 64'(fetch_target_rs), 64'(seq[i]));
            applyStimulus(0, 0, 1, 0);
        end
        checkOutput("lit_drained_empty", 64'(empty), 64'd1);

        // Wrap pointers: six more entries through the ring.
        for (int i = 0; i < 3; i++) applyStimulus(1, 3'($urandom_range(0, 2)), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 3'($urandom_range(0, 2)), 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("lit_wrap_empty", 64'(empty), 64'd1);

        applyStimulus(1, 3'd1, 0, 0);
        applyStimulus(1, 3'd2, 1, 0);
        checkOutput("lit_simul_count", 64'(count), 64'd1);
        checkOutput("lit_simul_head", 64'(fetch_target_rs), 64'd2);
        applyStimulus(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 3'd0, 0, 0);
        applyStimulus(1, 3'd1, 1, 1);
        checkOutput("lit_flush_count", 64'(count), 64'd0);
        checkOutput("lit_flush_valid", 64'(fetch_valid), 64'd0);

        applyStimulus(1, 3'd0, 0, 0);
        applyStimulus(1, 3'd5, 0, 0);
        checkOutput("lit_bad_count", 64'(count), 64'd1);
        checkOutput("lit_bad_set", 64'(bad_target), 64'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit_bad_after_flush", 64'(bad_target), 64'd1);

        // Randomized traffic with an asynchronous reset pulse midway.
        for (int i = 0; i < 800; i++) begin
            bit ev, poll, fl;
            logic [2:0] tgt;
            ev   = ($urandom_range(0, 9) < 7);
            poll = ($urandom_range(0, 1) == 1);
            fl   = ($urandom_range(0, 29) == 0);
            tgt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            applyStimulus(ev, tgt, poll, fl);
            if (i == 400) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("lit_async_reset_count", 64'(count), 64'd0);
                checkOutput("lit_async_reset_bad", 64'(bad_target), 64'd0);
                rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
